uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- 8-bit UART transmitter. Serialises a byte as an 8N1 frame: start, 8 data, stop.
- Transmit-side counterpart of the team's UART receiver, sharing the same Fclk/Fuart parameterisation.
- Byte source hands data over through a valid/ready handshake; the Tx line drives the board UART pin.

Parameters:
- Fclk, 100000000, input clock frequency [Hz]
- Fuart, 9600, baud rate [bit/s]
- divider, (Fclk / Fuart) - 1, clocks per bit minus 1; must fit in 16 bits
- MSB_FIRST, 0, 0 = data sent LSB first (standard UART); 1 = MSB first

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- tx_data  input  8  byte to send; sampled only at handshake
- tx_valid  input  1  source has a byte
- tx_ready  output  1  transmitter can accept a byte
- Tx  output  1  serial line, idle high
- busy  output  1  frame in progress

Behaviour:
- Reset values (on any posedge clk with rst=1): Tx=1, tx_ready=1, busy=0, state=IDLE, baud counter=0, bit counter=0, shift reg=0.
- Reset mid-frame aborts the frame. Tx=1 from the next edge; no partial stop bit is emitted.
- Baud counter: 16-bit.
  - Runs only in non-IDLE states; counts 0..divider.
  - Tick when count==divider; the count then wraps to 0.
  - Forced to 0 on handshake.
- Handshake: accept when tx_valid && tx_ready at posedge clk.
  - tx_ready=1 only in IDLE.
  - tx_data is latched into the shift register at accept; later tx_data changes are ignored.
- FSM states: IDLE -> START -> DATA -> STOP -> IDLE (PARITY between DATA and STOP if enabled).
  - IDLE: Tx=1, busy=0. On accept: go to START; from the next cycle Tx=0, busy=1, tx_ready=0.
  - START: Tx=0 for divider+1 clocks. On tick: go to DATA with bit counter=0.
  - DATA: Tx = shift-register bit 0 (or bit 7 if MSB_FIRST). On each tick: shift, bit counter+1. On the tick with bit counter==7: exit state.
  - STOP: Tx=1 for divider+1 clocks. On tick: go to IDLE.
- Frame length: 10*(divider+1) clocks from the first Tx=0 cycle to the first IDLE cycle.
- Back-to-back frames: if tx_valid is held high, the next accept happens in the first IDLE cycle.
  - Minimum gap: the stop bit plus 1 clock high before the next start bit.
- tx_valid asserted while busy: ignored; no accept. Source must hold it until tx_ready.
- Simultaneous rst and tx_valid: reset wins; no accept.
- All outputs registered; Tx is glitch-free.

Optional Feature:
- Macro: UART_TX_PARITY_EN
- Defined:
  - PARITY state is inserted after DATA.
  - Tx = XOR of the 8 latched data bits (even parity) for divider+1 clocks.
  - Frame becomes 11 bit-times; FSM order is START-DATA-PARITY-STOP.
- Not defined: no PARITY state; 10 bit-time 8N1 frame.

Test Plan (sim params Fclk=1000000, Fuart=100000 -> divider=9, 10 clk/bit):
- Reset, then idle 50 clk with tx_valid=0 -> Tx=1, tx_ready=1, busy=0 throughout.
- tx_data=0xA5, tx_valid pulse 1 clk:
  - Tx=0 for 10 clk, then bits 1,0,1,0,0,1,0,1 (10 clk each), then 1 for 10 clk.
  - busy high exactly 100 clk; tx_ready low for the same 100 clk.
- tx_valid held high with 0x00 then 0xFF:
  - Two complete frames; 11 high clocks between the frames.
  - tx_data change during frame 1 does not corrupt frame 1.
- MSB_FIRST=1, tx_data=0x01 -> data bits 0,0,0,0,0,0,0,1.
- rst asserted 35 clk after accept of 0x3C -> Tx=1, busy=0, tx_ready=1 on the next edge; a new byte 0x55 then sends a full correct frame.
- UART_TX_PARITY_EN defined:
  - 0xA5 -> parity bit 0.
  - 0x07 -> parity bit 1.
  - busy high 110 clk.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte handshake between a byte source and the UART transmitter.
// The source drives tx_data/tx_valid; the transmitter answers with tx_ready.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte intake; all outputs registered.
// Optional even-parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int unsigned Fclk      = 100000000,
  parameter int unsigned Fuart     = 9600,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus,
  output logic      Tx,
  output logic      busy
);

  localparam int unsigned DIVIDER = (Fclk / Fuart) - 1;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [2:0]         bit_cnt, bit_next;
  logic [7:0]         shift, shift_next;
  logic               tx_next, busy_next;
  logic               ready, ready_next;
  logic               tick_c;
`ifdef UART_TX_PARITY_EN
  logic               parity, parity_next;
`endif

  assign bus.tx_ready = ready;

  // Bit presented on the line from the current shift register contents.
  function automatic logic out_bit(input logic [7:0] s);
    return (MSB_FIRST != 0) ? s[7] : s[0];
  endfunction

  function automatic logic [7:0] shifted(input logic [7:0] s);
    return (MSB_FIRST != 0) ? {s[6:0], 1'b0} : {1'b0, s[7:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      Tx      <= 1'b1;
      busy    <= 1'b0;
      ready   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_cnt <= bit_next;
      shift   <= shift_next;
      Tx      <= tx_next;
      busy    <= busy_next;
      ready   <= ready_next;
`ifdef UART_TX_PARITY_EN
      parity  <= parity_next;
`endif
    end
  end

  // Next state and next registered outputs; the line only changes on bit boundaries.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    tx_next    = Tx;
    busy_next  = busy;
    ready_next = ready;
`ifdef UART_TX_PARITY_EN
    parity_next = parity;
`endif
    tick_c = (cnt == CNT_W'(DIVIDER));

    if (state != IDLE) begin
      cnt_next = tick_c ? '0 : cnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        if (bus.tx_valid && ready) begin
          state_next = START;
          cnt_next   = '0;
          shift_next = bus.tx_data;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
          ready_next = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_next = ^bus.tx_data;
`endif
        end
      end
      START: begin
        if (tick_c) begin
          state_next = DATA;
          bit_next   = '0;
          tx_next    = out_bit(shift);
        end
      end
      DATA: begin
        if (tick_c) begin
          shift_next = shifted(shift);
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = parity;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            tx_next = out_bit(shifted(shift));
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick_c) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick_c) begin
          state_next = IDLE;
          tx_next    = 1'b1;
          busy_next  = 1'b0;
          ready_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        ready_next = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed and random frames on an LSB-first and an MSB-first instance,
// compared clock by clock against a bit-time model of the UART frame.
module tb_uart_tx;

  localparam int unsigned FCLK  = 1000000;
  localparam int unsigned FUART = 100000;
  localparam int          BT    = 10;
`ifdef UART_TX_PARITY_EN
  localparam int          NB    = 11;
`else
  localparam int          NB    = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  logic tx0, tx1, busy0, busy1;

  int checks = 0;
  int errors = 0;

  uart_tx #(.Fclk(FCLK), .Fuart(FUART), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .bus(if0), .Tx(tx0), .busy(busy0));

  uart_tx #(.Fclk(FCLK), .Fuart(FUART), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .bus(if1), .Tx(tx1), .busy(busy1));

  // Expected line level during bit-time idx of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input bit msb, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return msb ? d[8 - idx] : d[idx - 1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  function automatic logic get_tx(input bit sel);
    return sel ? tx1 : tx0;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? busy1 : busy0;
  endfunction
  function automatic logic get_ready(input bit sel);
    return sel ? if1.tx_ready : if0.tx_ready;
  endfunction

  task automatic drive(input bit sel, input logic [7:0] d, input logic v);
    if (sel) begin
      if1.tx_data = d; if1.tx_valid = v;
    end else begin
      if0.tx_data = d; if0.tx_valid = v;
    end
  endtask

  task automatic set_data(input bit sel, input logic [7:0] d);
    if (sel) if1.tx_data = d; else if0.tx_data = d;
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) if1.tx_valid = v; else if0.tx_valid = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input bit sel, input string tag);
    check({tag, "_idle"}, {29'd0, get_tx(sel), get_ready(sel), get_busy(sel)}, 32'b110);
  endtask

  // Called at a negedge with valid already high; returns just after the accepting posedge.
  task automatic wait_accept(input bit sel, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (get_ready(sel)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    else check({tag, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  // Checks every clock of a frame after acceptance, then the first idle cycle.
  task automatic expect_frame(input bit sel, input logic [7:0] d, input string tag,
                              input bit drop_valid, input int change_at,
                              input logic [7:0] new_data);
    for (int n = 0; n < NB * BT; n++) begin
      @(negedge clk);
      if (n == 0 && drop_valid) set_valid(sel, 1'b0);
      if (n == change_at) set_data(sel, new_data);
      check($sformatf("%s_tx_clk%0d", tag, n), {31'd0, get_tx(sel)},
            {31'd0, exp_bit(d, sel, n / BT)});
      check($sformatf("%s_busy_clk%0d", tag, n), {31'd0, get_busy(sel)}, 32'd1);
      check($sformatf("%s_ready_clk%0d", tag, n), {31'd0, get_ready(sel)}, 32'd0);
    end
    @(negedge clk);
    check_idle(sel, {tag, "_end"});
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input string tag);
    drive(sel, d, 1'b1);
    wait_accept(sel, tag);
    expect_frame(sel, d, tag, 1'b1, -1, 8'h00);
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle(1'b0, "reset_lsb");
    check_idle(1'b1, "reset_msb");
    rst = 1'b0;

    // Idle line with no requests
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_idle(1'b0, $sformatf("idle_%0d", i));
    end

    send(1'b0, 8'hA5, "a5_pulse");

    // Held valid: two back-to-back frames, data changed mid-frame 1
    drive(1'b0, 8'h00, 1'b1);
    wait_accept(1'b0, "b2b_0");
    expect_frame(1'b0, 8'h00, "b2b_0", 1'b0, 20, 8'hFF);
    wait_accept(1'b0, "b2b_1");
    expect_frame(1'b0, 8'hFF, "b2b_1", 1'b1, -1, 8'h00);

    send(1'b1, 8'h01, "msb_01");
    send(1'b1, 8'hA5, "msb_a5");

    // Reset 35 clocks into a frame
    drive(1'b0, 8'h3C, 1'b1);
    wait_accept(1'b0, "abort");
    for (int n = 0; n < 35; n++) begin
      @(negedge clk);
      if (n == 0) set_valid(1'b0, 1'b0);
      check($sformatf("abort_tx_clk%0d", n), {31'd0, tx0}, {31'd0, exp_bit(8'h3C, 1'b0, n / BT)});
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle(1'b0, "abort_reset");
    rst = 1'b0;
    send(1'b0, 8'h55, "after_abort");

    // Reset and valid together: no accept
    rst = 1'b1;
    drive(1'b0, 8'h99, 1'b1);
    @(negedge clk);
    check_idle(1'b0, "rst_vs_valid");
    rst = 1'b0;
    set_valid(1'b0, 1'b0);
    @(negedge clk);
    check_idle(1'b0, "rst_vs_valid_after");

`ifdef UART_TX_PARITY_EN
    send(1'b0, 8'hA5, "par_a5");
    send(1'b0, 8'h07, "par_07");
`endif

    // Random bytes on either instance with random idle gaps
    for (int k = 0; k < 6; k++) begin
      bit          sel;
      logic [7:0]  d;
      int          gap;
      sel = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      gap = int'($urandom_range(0, 5));
      repeat (gap) begin
        @(negedge clk);
        check_idle(sel, $sformatf("rand%0d_gap", k));
      end
      send(sel, d, $sformatf("rand%0d_%02h", k, d));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
